// File: rtl/pspin_lite_pkg.sv
// pspin_lite_pkg: shared widths, descriptor types and the handler cost model.
package pspin_lite_pkg;

    localparam int MSGID_W             = 10;
    localparam int ADDR_W              = 32;
    localparam int SIZE_W              = 16;
    localparam int HANDLER_BASE_CYCLES = 4;
    localparam int BYTES_PER_CYCLE     = 8;
    localparam int BPC_SH              = $clog2(BYTES_PER_CYCLE);

    typedef struct packed {
        logic [MSGID_W-1:0] msgid;
        logic [ADDR_W-1:0]  addr;
        logic [SIZE_W-1:0]  size;
    } her_descr_t;

    typedef struct packed {
        logic [MSGID_W-1:0] msgid;
        logic [ADDR_W-1:0]  addr;
        logic [SIZE_W-1:0]  size;
    } feedback_descr_t;

    typedef enum logic {HPU_IDLE, HPU_BUSY} hpu_state_e;

    // One extra bit keeps the rounding add from overflowing at the max size.
    function automatic logic [SIZE_W:0] handler_cycles(input logic [SIZE_W-1:0] size);
        return (({1'b0, size} + (SIZE_W+1)'(BYTES_PER_CYCLE - 1)) >> BPC_SH)
               + (SIZE_W+1)'(HANDLER_BASE_CYCLES);
    endfunction

endpackage

// File: rtl/pspin_hpu_timer.sv
// pspin_hpu_timer: one emulated HPU; counts down the handler cost, then holds
// its completion request until granted.
module pspin_hpu_timer
    import pspin_lite_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  her_descr_t      descr_i,
    input  logic            grant_i,
    output logic            busy_o,
    output logic            req_o,
    output feedback_descr_t descr_o
);

    hpu_state_e        state_q;
    logic [SIZE_W:0]   cnt_q;
    her_descr_t        descr_q;

    assign busy_o  = state_q == HPU_BUSY;
    assign req_o   = busy_o && cnt_q == (SIZE_W+1)'(1);
    assign descr_o = feedback_descr_t'(descr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HPU_IDLE;
            cnt_q   <= '0;
            descr_q <= '0;
        end else begin
            case (state_q)
                HPU_IDLE: if (load_i) begin
                    state_q <= HPU_BUSY;
                    cnt_q   <= handler_cycles(descr_i.size);
                    descr_q <= descr_i;
                end
                HPU_BUSY: begin
                    if (grant_i) state_q <= HPU_IDLE;
                    if (cnt_q > (SIZE_W+1)'(1)) cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= HPU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pspin_lite_fifo.sv
// pspin_lite_fifo: generic synchronous FIFO, power-of-two depth, registered full/empty.
module pspin_lite_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    logic           do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/pspin_lite_top.sv
// pspin_lite_top: HER queue, lowest-index dispatch onto NUM_HPUS timers,
// fixed-priority completion into the feedback queue, activity and eos tracking.
module pspin_lite_top
    import pspin_lite_pkg::*;
#(
    parameter int NUM_HPUS       = 4,
    parameter int HER_FIFO_DEPTH = 8,
    parameter int FB_FIFO_DEPTH  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               her_valid_i,
    output logic               her_ready_o,
    input  logic [MSGID_W-1:0] her_msgid_i,
    input  logic [ADDR_W-1:0]  her_addr_i,
    input  logic [SIZE_W-1:0]  her_size_i,
    output logic               feedback_valid_o,
    input  logic               feedback_ready_i,
    output logic [MSGID_W-1:0] feedback_msgid_o,
    output logic [ADDR_W-1:0]  feedback_addr_o,
    output logic [SIZE_W-1:0]  feedback_size_o,
    input  logic               eos_i,
    output logic               pspin_active_o,
    output logic               done_o
);

    logic                init_q, eos_q;
    her_descr_t          her_in, her_head;
    feedback_descr_t     fb_in, fb_head;
    logic                her_empty, her_full, her_push, her_pop;
    logic                fb_empty, fb_full, fb_push, fb_pop;
    logic [NUM_HPUS-1:0] busy, req, load, gnt;
    feedback_descr_t     hpu_descr [NUM_HPUS];

    // Ready stays low during reset and for the first edge after release.
    assign her_ready_o = init_q && !her_full;
    assign her_push    = her_valid_i && her_ready_o;
    assign her_in      = '{msgid: her_msgid_i, addr: her_addr_i, size: her_size_i};
    assign her_pop     = !her_empty && !(&busy);
    assign load        = her_pop ? ~busy & (busy + 1'b1) : '0;
    assign gnt         = fb_full ? '0 : req & (~req + 1'b1);
    assign fb_push     = |req && !fb_full;
    assign fb_pop      = !fb_empty && feedback_ready_i;

    always_comb begin
        fb_in = '0;
        for (int i = 0; i < NUM_HPUS; i++)
            if (gnt[i]) fb_in = hpu_descr[i];
    end

    assign feedback_valid_o = !fb_empty;
    assign feedback_msgid_o = fb_empty ? '0 : fb_head.msgid;
    assign feedback_addr_o  = fb_empty ? '0 : fb_head.addr;
    assign feedback_size_o  = fb_empty ? '0 : fb_head.size;
    assign pspin_active_o   = !her_empty || |busy || !fb_empty;
    assign done_o           = eos_q && !pspin_active_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q <= 1'b0;
            eos_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            eos_q  <= eos_q || eos_i;
        end
    end

    pspin_lite_fifo #(.DEPTH(HER_FIFO_DEPTH), .T(her_descr_t)) u_her_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(her_push), .data_i(her_in),
        .pop_i(her_pop), .data_o(her_head), .empty_o(her_empty), .full_o(her_full)
    );

    pspin_lite_fifo #(.DEPTH(FB_FIFO_DEPTH), .T(feedback_descr_t)) u_fb_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(fb_push), .data_i(fb_in),
        .pop_i(fb_pop), .data_o(fb_head), .empty_o(fb_empty), .full_o(fb_full)
    );

    for (genvar g = 0; g < NUM_HPUS; g++) begin : g_hpu
        pspin_hpu_timer u_hpu (
            .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load[g]), .descr_i(her_head),
            .grant_i(gnt[g]), .busy_o(busy[g]), .req_o(req[g]), .descr_o(hpu_descr[g])
        );
    end

endmodule

// File: tb/tb_pspin_lite_top.sv
// tb_pspin_lite_top: directed and random traffic against a transaction-level
// model; a negedge monitor scores every feedback pop and the status outputs.
module tb_pspin_lite_top;
    import pspin_lite_pkg::*;

    localparam int NH = 4, HD = 8, FD = 4;

    logic               clk_i = 0, rst_ni = 0;
    logic               her_valid_i = 0, her_ready_o;
    logic [MSGID_W-1:0] her_msgid_i = '0;
    logic [ADDR_W-1:0]  her_addr_i = '0;
    logic [SIZE_W-1:0]  her_size_i = '0;
    logic               feedback_valid_o, feedback_ready_i = 1;
    logic [MSGID_W-1:0] feedback_msgid_o;
    logic [ADDR_W-1:0]  feedback_addr_o;
    logic [SIZE_W-1:0]  feedback_size_o;
    logic               eos_i = 0, pspin_active_o, done_o;

    pspin_lite_top #(.NUM_HPUS(NH), .HER_FIFO_DEPTH(HD), .FB_FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .her_valid_i(her_valid_i), .her_ready_o(her_ready_o),
        .her_msgid_i(her_msgid_i), .her_addr_i(her_addr_i), .her_size_i(her_size_i),
        .feedback_valid_o(feedback_valid_o), .feedback_ready_i(feedback_ready_i),
        .feedback_msgid_o(feedback_msgid_o), .feedback_addr_o(feedback_addr_o),
        .feedback_size_o(feedback_size_o), .eos_i(eos_i),
        .pspin_active_o(pspin_active_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    function automatic void check(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Reference model: pending HERs, per-HPU job and its due edge, feedback queue.
    her_descr_t hq[$], fq[$], exp_q[$];
    her_descr_t m_desc [NH];
    bit         m_busy [NH];
    int         m_due  [NH];
    bit         m_init, m_eos;
    int         cyc, m_g, m_j;
    bit         m_rdy, m_pop, m_full;
    logic [MSGID_W-1:0] got[$];

    function automatic int cost(int s);
        return HANDLER_BASE_CYCLES + (s + BYTES_PER_CYCLE - 1) / BYTES_PER_CYCLE;
    endfunction

    function automatic bit m_active();
        bit b = hq.size() > 0 || fq.size() > 0;
        for (int i = 0; i < NH; i++) b |= m_busy[i];
        return b;
    endfunction

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            hq.delete(); fq.delete(); exp_q.delete();
            for (int i = 0; i < NH; i++) m_busy[i] = 0;
            m_init = 0; m_eos = 0;
        end else begin
            cyc++;
            m_rdy  = m_init && hq.size() < HD;
            m_pop  = fq.size() > 0 && feedback_ready_i;
            m_full = fq.size() == FD;
            m_g = -1; m_j = -1;
            for (int i = 0; i < NH; i++) if (m_g < 0 && m_busy[i] && cyc >= m_due[i]) m_g = i;
            for (int i = 0; i < NH; i++) if (m_j < 0 && !m_busy[i]) m_j = i;
            if (m_full) m_g = -1;
            if (hq.size() == 0) m_j = -1;
            if (m_pop) void'(fq.pop_front());
            if (m_g >= 0) begin
                fq.push_back(m_desc[m_g]);
                exp_q.push_back(m_desc[m_g]);
                m_busy[m_g] = 0;
            end
            if (m_j >= 0) begin
                m_desc[m_j] = hq.pop_front();
                m_busy[m_j] = 1;
                m_due[m_j]  = cyc + cost(int'(m_desc[m_j].size));
            end
            if (her_valid_i && m_rdy)
                hq.push_back('{msgid: her_msgid_i, addr: her_addr_i, size: her_size_i});
            if (eos_i) m_eos = 1;
            m_init = 1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            her_descr_t e;
            bit act;
            act = m_active();
            check("her_ready", her_ready_o, m_init && hq.size() < HD);
            check("fb_valid", feedback_valid_o, fq.size() > 0);
            check("active", pspin_active_o, act);
            check("done", done_o, m_eos && !act);
            if (feedback_valid_o && feedback_ready_i) begin
                if (exp_q.size() == 0) check("fb_unexpected", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("fb_msgid", feedback_msgid_o, e.msgid);
                    check("fb_addr", feedback_addr_o, e.addr);
                    check("fb_size", feedback_size_o, e.size);
                end
                got.push_back(feedback_msgid_o);
            end
        end
    end

    task automatic do_reset();
        her_valid_i = 0; eos_i = 0; rst_ni = 0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outs", {her_ready_o, feedback_valid_o, feedback_msgid_o, feedback_addr_o,
                             feedback_size_o, pspin_active_o, done_o}, 0);
        @(posedge clk_i); #2 rst_ni = 1;
        @(negedge clk_i); check("ready_at_release", her_ready_o, 0);
        @(negedge clk_i); check("ready_after_release", her_ready_o, 1);
        @(posedge clk_i); #2;
    endtask

    task automatic send(input int id, input int a, input int s);
        bit rdy;
        int n = 0;
        her_valid_i = 1;
        her_msgid_i = MSGID_W'(id); her_addr_i = ADDR_W'(a); her_size_i = SIZE_W'(s);
        do begin
            @(negedge clk_i); rdy = her_ready_o; n++;
            @(posedge clk_i); #2;
        end while (!rdy && n < 500);
        her_valid_i = 0;
        if (!rdy) check("send_timeout", rdy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_i);
        while (pspin_active_o && n < 3000) begin @(negedge clk_i); n++; end
        check("idle_timeout", n < 3000, 1);
        @(posedge clk_i); #2;
    endtask

    initial begin
        int lat;
        bit seen;
        int ord[4] = '{1, 2, 3, 0};
        int hits;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hits;
        bit seen;
        int ord[4] = '{1, 2, 3, 0};
        do_reset();

        feedback_ready_i = 1;
        send(5, 'h1000, 64);
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(posedge clk_i); lat++;
            @(negedge clk_i); seen = feedback_valid_o;
        end
        check("latency", lat, 13);
        @(posedge clk_i); #2;
        wait_idle();

        got.delete();
        send(0, 'h2000, 256); send(1, 'h2100, 0); send(2, 'h2200, 0); send(3, 'h2300, 0);
        wait_idle();
        check("order_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("order_msgid", got[i], ord[i]);

        got.delete();
        send(20, 'h3000, 64); send(21, 'h3100, 56);
        wait_idle();
        check("collide_count", got.size(), 2);
        if (got.size() == 2) begin
            check("collide_first", got[0], 20);
            check("collide_second", got[1], 21);
        end

        got.delete();
        feedback_ready_i = 0;
        for (int i = 0; i < 16; i++) send(100 + i, 'h4000 + i, 0);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i); check("bp_ready_low", her_ready_o, 0);
        @(posedge clk_i); #2;
        feedback_ready_i = 1;
        wait_idle();
        check("bp_count", got.size(), 16);
        for (int m = 100; m < 116; m++) begin
            hits = 0;
            foreach (got[k]) if (got[k] == MSGID_W'(m)) hits++;
            check("bp_once", hits, 1);
        end

        send(40, 'h5000, 32); send(41, 'h5100, 8);
        eos_i = 1; @(posedge clk_i); #2 eos_i = 0;
        @(negedge clk_i); check("eos_busy_done", done_o, 0);
        @(posedge clk_i); #2;
        wait_idle();
        @(negedge clk_i); check("eos_done", done_o, 1);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i); check("eos_done_sticky", done_o, 1);
        @(posedge clk_i); #2;
        do_reset();

        for (int c = 0; c < 1200; c++) begin
            her_valid_i = 1'($urandom_range(0, 1));
            her_msgid_i = MSGID_W'($urandom);
            her_addr_i  = ADDR_W'($urandom);
            her_size_i  = $urandom_range(0, 3) == 0 ? SIZE_W'($urandom_range(0, 600))
                                                    : SIZE_W'($urandom_range(0, 40));
            feedback_ready_i = $urandom_range(0, 9) < 7;
            eos_i = $urandom_range(0, 299) == 0;
            @(posedge clk_i); #2;
        end
        do_reset();
        for (int c = 0; c < 800; c++) begin
            her_valid_i = 1'($urandom_range(0, 1));
            her_msgid_i = MSGID_W'($urandom);
            her_addr_i  = ADDR_W'($urandom);
            her_size_i  = SIZE_W'($urandom_range(0, 120));
            feedback_ready_i = $urandom_range(0, 9) < 5;
            eos_i = 0;
            @(posedge clk_i); #2;
        end
        her_valid_i = 0; feedback_ready_i = 1;
        wait_idle();
        check("drain_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
